onewire_master_ctrl: RTL and testbench
======================================

Name: onewire_master_ctrl

Overview:
Synthesisable, clock-driven 1-wire bus master that replaces the behavioural master task model used in simulation. Accepts reset/bit/byte commands over a valid/ready interface and drives one of OWN open-drain buses. Supports per-command overdrive timing. Returns presence and read data on a one-cycle response strobe. Sits between a register/CPU front end and the external pullup-terminated 1-wire pins.

Parameters:
OWN, 1, number of independent 1-wire buses (channels)
TICK_N, 100, clk cycles per normal-speed time unit (1 us at 100 MHz)
TICK_O, 12, clk cycles per overdrive time unit; used only for bit slots
SELW, $clog2(OWN) with a minimum of 1, width of the channel select

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid && ready
cmd_op  in  2  00 = reset/presence, 01 = single bit, 10 = byte, 11 = NOP
cmd_ovd  in  1  1 = overdrive timing for bit/byte slots
cmd_sel  in  SELW  target channel
cmd_data  in  8  bit to write (bit 0) or byte to write; write 1 = read slot
rsp_valid  out  1  one-cycle completion strobe
rsp_data  out  8  sampled bit(s); bit op fills bit 0, upper bits 0
rsp_presence  out  1  presence detected (reset op only, else 0)
busy  out  1  command in progress
owr_e  out  OWN  per-channel pull-low enable; pad is driven low when 1, else Z
owr_i  in  OWN  per-channel pad level

Behaviour:
- Reset (rst_n = 0 at a clk edge): state IDLE; owr_e = 0; cmd_ready = 1; rsp_valid = 0; rsp_data = 0; rsp_presence = 0; busy = 0; counters = 0. A reset mid-slot releases the bus on the next edge; the truncated low pulse is a permitted side effect.
- owr_i passes through a 2-flop synchroniser per channel. Only the selected channel is sampled.
- Prescaler: counts 0..T-1, where T = TICK_N for RST states and TICK_N or TICK_O (by latched ovd) for BIT states. Emits a unit tick on wrap. The unit counter is 10 bits and clears on each state entry.
- Accept: in IDLE with cmd_valid = 1, latch op, ovd, sel and data; cmd_ready = 0 and busy = 1 from the next cycle.
- FSM states: IDLE, RST_LOW, RST_WAIT, BIT_SLOT, BIT_REC, DONE.
- RST_LOW: owr_e[sel] = 1 for 480 units -> RST_WAIT with the bus released. At unit 70 of RST_WAIT, presence = (sync owr_i == 0). At unit 480 -> DONE. Total reset op is 960 units.
- BIT_SLOT (units): owr_e[sel] = 1 for 6 if the bit is 1, or 60 if the bit is 0. Sample at unit 15 (sample reg = sync owr_i). The slot ends at unit 65 -> BIT_REC, which releases for 5 units. Total slot is 70 units.
- Byte: 8 slots, LSB first. The shift register shifts right each slot; the sampled bit enters bit 7. After 8 slots the register holds the read byte, then -> DONE.
- NOP: IDLE -> DONE directly; rsp_data = 0.
- DONE: rsp_valid = 1 for exactly one cycle, with rsp_data and rsp_presence valid in that same cycle. Next state is IDLE with cmd_ready = 1. Minimum gap between completion and the next accept is 1 cycle.
- owr_e bits for non-selected channels are always 0. Only one channel is active at a time.
- A cmd_sel value >= OWN is accepted; owr_e stays all 0 and the read sees 0 (the pad is not driven). The response still returns: presence = 0 after reset op, because the unselected sample reads as the synchroniser default. This behaviour is defined by this spec; the bench checks it.
- A write of 0 sampling 0 is normal, and rsp reflects the sampled value. Collision (wrote 1, sampled 0) is not flagged.
- Latency from accept to rsp_valid: reset = 960*TICK_N + 2 clk; bit = 70*T + 2; byte = 560*T + 2.

Test Plan:
1. TICK_N = 4, one slave present. Reset op -> owr_e[0] low for exactly 1920 clk; rsp_valid after 3842 clk; rsp_presence = 1.
2. No slave, owr_i tied 1. Reset op -> rsp_presence = 0; no owr_e activity on other channels.
3. Byte write 0x55, normal mode -> bus shows low pulses of 6/60 units in pattern 1,0,1,0,1,0,1,0; rsp_data = 0x55 (echo of the pulled-up line).
4. Slave returning 0xA3, byte op with data 0xFF, cmd_ovd = 1, TICK_O = 1 -> each slot is 70 clk; rsp_data = 0xA3.
5. OWN = 3, cmd_sel = 2, bit op with data 0 -> only owr_e[2] asserted for 60 units; cmd_sel = 3 -> owr_e stays 0 and a response still arrives.
6. rst_n low during byte slot 4 -> next edge owr_e = 0, busy = 0, cmd_ready = 1, no rsp_valid. The next reset op completes normally.

Source files
------------

// File: rtl/onewire_master_ctrl_if.sv
// Command/response handshake between a CPU/register front end and the 1-wire master.
interface onewire_master_ctrl_if #(
    parameter int unsigned SELW = 1
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic            cmd_ovd;
    logic [SELW-1:0] cmd_sel;
    logic [7:0]      cmd_data;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_presence;
    logic            busy;

    modport master (
        output cmd_valid, cmd_op, cmd_ovd, cmd_sel, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ovd, cmd_sel, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, busy
    );
endinterface

// File: rtl/onewire_master_ctrl.sv
// Clock-driven 1-wire bus master: reset/presence, bit and byte slots on one of OWN
// open-drain channels, with optional overdrive timing for bit slots.
module onewire_master_ctrl #(
    parameter int unsigned OWN    = 1,
    parameter int unsigned TICK_N = 100,
    parameter int unsigned TICK_O = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onewire_master_ctrl_if.slave   bus,
    output logic [OWN-1:0]         owr_e,
    input  logic [OWN-1:0]         owr_i
);
    localparam int unsigned SELW = (OWN > 1) ? $clog2(OWN) : 1;
    localparam int unsigned TMAX = (TICK_N > TICK_O) ? TICK_N : TICK_O;
    localparam int unsigned PW   = $clog2(TMAX + 1);
    localparam int unsigned UW   = 10;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_LOW  = 3'd1;
    localparam logic [2:0] S_RST_WAIT = 3'd2;
    localparam logic [2:0] S_BIT_SLOT = 3'd3;
    localparam logic [2:0] S_BIT_REC  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_BIT  = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;

    logic [2:0]      r_state, w_state_nx;
    logic [PW-1:0]   r_pre, w_pre_nx;
    logic [UW-1:0]   r_unit, w_unit_nx;
    logic [1:0]      r_op, w_op_nx;
    logic            r_ovd, w_ovd_nx;
    logic [SELW-1:0] r_sel, w_sel_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic [2:0]      r_bitn, w_bitn_nx;
    logic            r_samp, w_samp_nx;
    logic            r_pres, w_pres_nx;
    logic [OWN-1:0]  r_sync1, r_sync2;
    logic [OWN-1:0]  r_owr_e, w_owr_e_nx;
    logic            r_ready, r_busy;
    logic            r_rsp_valid, w_rsp_valid_nx;
    logic [7:0]      r_rsp_data, w_rsp_data_nx;
    logic            r_rsp_pres, w_rsp_pres_nx;

    logic [PW-1:0]   w_tper;
    logic            w_tick;
    logic            w_samp;
    logic            w_sel_ok;
    logic            w_drive;

    assign owr_e            = r_owr_e;
    assign bus.cmd_ready    = r_ready;
    assign bus.busy         = r_busy;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_presence = r_rsp_pres;

    // Unit period: overdrive only shortens bit slots, never the reset pulse.
    always_comb begin
        w_tper = PW'(TICK_N);
        if ((r_state == S_BIT_SLOT || r_state == S_BIT_REC) && r_ovd)
            w_tper = PW'(TICK_O);
        w_tick   = (r_pre == w_tper - PW'(1));
        w_sel_ok = (32'(r_sel) < OWN);
        // Out-of-range select reads the synchroniser idle level.
        w_samp = 1'b1;
        for (int i = 0; i < OWN; i++)
            if (r_sel == SELW'(i)) w_samp = r_sync2[i];
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nx     = r_state;
        w_op_nx        = r_op;
        w_ovd_nx       = r_ovd;
        w_sel_nx       = r_sel;
        w_shift_nx     = r_shift;
        w_bitn_nx      = r_bitn;
        w_samp_nx      = r_samp;
        w_pres_nx      = r_pres;
        w_rsp_valid_nx = 1'b0;
        w_rsp_data_nx  = r_rsp_data;
        w_rsp_pres_nx  = r_rsp_pres;
        w_pre_nx       = '0;
        w_unit_nx      = '0;
        w_owr_e_nx     = '0;
        w_drive        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_nx    = bus.cmd_op;
                    w_ovd_nx   = bus.cmd_ovd;
                    w_sel_nx   = bus.cmd_sel;
                    w_shift_nx = bus.cmd_data;
                    w_bitn_nx  = 3'd0;
                    w_samp_nx  = 1'b0;
                    w_pres_nx  = 1'b0;
                    case (bus.cmd_op)
                        OP_RST:          w_state_nx = S_RST_LOW;
                        OP_BIT, OP_BYTE: w_state_nx = S_BIT_SLOT;
                        default:         w_state_nx = S_DONE;
                    endcase
                end
            end
            S_RST_LOW: begin
                if (w_tick && r_unit == UW'(479)) w_state_nx = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                if (w_tick && r_unit == UW'(69)) w_pres_nx = ~w_samp;
                if (w_tick && r_unit == UW'(479)) w_state_nx = S_DONE;
            end
            S_BIT_SLOT: begin
                if (w_tick && r_unit == UW'(14)) w_samp_nx = w_samp;
                if (w_tick && r_unit == UW'(64)) w_state_nx = S_BIT_REC;
            end
            S_BIT_REC: begin
                if (w_tick && r_unit == UW'(4)) begin
                    w_shift_nx = {r_samp, r_shift[7:1]};
                    if (r_op == OP_BYTE && r_bitn != 3'd7) begin
                        w_bitn_nx  = r_bitn + 3'd1;
                        w_state_nx = S_BIT_SLOT;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_rsp_valid_nx = 1'b1;
                w_rsp_pres_nx  = (r_op == OP_RST) && w_sel_ok && r_pres;
                case (r_op)
                    OP_BIT:  w_rsp_data_nx = {7'd0, r_samp};
                    OP_BYTE: w_rsp_data_nx = r_shift;
                    default: w_rsp_data_nx = 8'd0;
                endcase
                if (!w_sel_ok) w_rsp_data_nx = 8'd0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Prescaler and unit counter restart on every state entry.
        if (w_state_nx == r_state && r_state != S_IDLE) begin
            if (w_tick) begin
                w_unit_nx = r_unit + UW'(1);
            end else begin
                w_pre_nx  = r_pre + PW'(1);
                w_unit_nx = r_unit;
            end
        end

        w_drive = (w_state_nx == S_RST_LOW) ||
                  (w_state_nx == S_BIT_SLOT &&
                   w_unit_nx < (w_shift_nx[0] ? UW'(6) : UW'(60)));
        for (int i = 0; i < OWN; i++)
            w_owr_e_nx[i] = w_drive && (r_sel == SELW'(i) || w_sel_nx == SELW'(i)) &&
                            (w_sel_nx == SELW'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_unit      <= '0;
            r_op        <= 2'b11;
            r_ovd       <= 1'b0;
            r_sel       <= '0;
            r_shift     <= '0;
            r_bitn      <= '0;
            r_samp      <= 1'b0;
            r_pres      <= 1'b0;
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_owr_e     <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_pres  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pre       <= w_pre_nx;
            r_unit      <= w_unit_nx;
            r_op        <= w_op_nx;
            r_ovd       <= w_ovd_nx;
            r_sel       <= w_sel_nx;
            r_shift     <= w_shift_nx;
            r_bitn      <= w_bitn_nx;
            r_samp      <= w_samp_nx;
            r_pres      <= w_pres_nx;
            r_sync1     <= owr_i;
            r_sync2     <= r_sync1;
            r_owr_e     <= w_owr_e_nx;
            r_ready     <= (w_state_nx == S_IDLE);
            r_busy      <= (w_state_nx != S_IDLE);
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_data  <= w_rsp_data_nx;
            r_rsp_pres  <= w_rsp_pres_nx;
        end
    end
endmodule

// File: tb/tb_onewire_master_ctrl.sv
// Directed bench for onewire_master_ctrl: three channels, a behavioural slave on channel 0.
module tb_onewire_master_ctrl;
    localparam int unsigned OWN    = 3;
    localparam int unsigned TICK_N = 4;
    localparam int unsigned TICK_O = 1;
    localparam int unsigned SELW   = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [OWN-1:0] owr_e;
    logic [OWN-1:0] owr_i;
    logic           rel0 = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Slave model controls and bus monitors
    logic       slave_en = 1'b0;
    int         slave_t  = 4;
    logic [7:0] slave_bits = 8'h00;
    int         bitidx = 0;
    int         e_cnt [OWN];
    int         pulses [16];
    int         npulse = 0;
    int         rsp_seen = 0;

    onewire_master_ctrl_if #(.SELW(SELW)) ow_if ();

    onewire_master_ctrl #(.OWN(OWN), .TICK_N(TICK_N), .TICK_O(TICK_O)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ow_if),
        .owr_e (owr_e),
        .owr_i (owr_i)
    );

    always #5 clk = ~clk;

    assign owr_i = ~owr_e & {1'b1, 1'b1, rel0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Channel-0 slave: presence after long low, holds line low for read-0 slots.
    initial begin
        int lowcnt = 0;
        int hold = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < OWN; i++) if (owr_e[i]) e_cnt[i]++;
            if (ow_if.rsp_valid) rsp_seen++;
            if (owr_e[0]) begin
                lowcnt++;
            end else begin
                if (lowcnt != 0) begin
                    if (npulse < 16) pulses[npulse] = lowcnt;
                    npulse++;
                    if (slave_en && lowcnt >= 400 * TICK_N) begin
                        hold = 100 * TICK_N;
                    end else if (lowcnt < 15 * slave_t) begin
                        if (slave_en && !slave_bits[bitidx[2:0]]) hold = 30 * slave_t;
                        bitidx++;
                    end
                end
                lowcnt = 0;
            end
            if (hold > 0) begin
                rel0 = 1'b0;
                hold--;
            end else begin
                rel0 = 1'b1;
            end
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < OWN; i++) e_cnt[i] = 0;
        npulse = 0;
        bitidx = 0;
        rsp_seen = 0;
    endtask

    // Issue one command; lat counts clocks from the accept edge (as 1) to the rsp_valid cycle.
    task automatic run_cmd(input logic [1:0] op, input logic ovd, input logic [SELW-1:0] sel,
                           input logic [7:0] data, output int lat,
                           output logic [7:0] rdata, output logic pres);
        clear_mon();
        @(negedge clk);
        ow_if.cmd_valid = 1'b1;
        ow_if.cmd_op    = op;
        ow_if.cmd_ovd   = ovd;
        ow_if.cmd_sel   = sel;
        ow_if.cmd_data  = data;
        @(posedge clk);
        #1;
        ow_if.cmd_valid = 1'b0;
        lat   = 1;
        rdata = 8'hxx;
        pres  = 1'bx;
        while (lat < 20000) begin
            @(posedge clk);
            #1;
            lat++;
            if (ow_if.rsp_valid) begin
                rdata = ow_if.rsp_data;
                pres  = ow_if.rsp_presence;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int         lat;
        logic [7:0] rd;
        logic       pr;

        ow_if.cmd_valid = 1'b0;
        ow_if.cmd_op    = 2'b11;
        ow_if.cmd_ovd   = 1'b0;
        ow_if.cmd_sel   = '0;
        ow_if.cmd_data  = 8'h00;
        for (int i = 0; i < OWN; i++) e_cnt[i] = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_ready",    32'(ow_if.cmd_ready), 32'd1);
        check_eq("rst_busy",     32'(ow_if.busy), 32'd0);
        check_eq("rst_rsp_valid",32'(ow_if.rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(ow_if.rsp_data), 32'd0);
        check_eq("rst_owr_e",    32'(owr_e), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset op with slave present
        slave_en = 1'b1; slave_t = TICK_N;
        run_cmd(2'b00, 1'b0, 2'd0, 8'h00, lat, rd, pr);
        check_eq("pres_lat",  32'(lat), 32'(960 * TICK_N + 2));
        check_eq("pres_low",  32'(e_cnt[0]), 32'(480 * TICK_N));
        check_eq("pres_bit",  32'(pr), 32'd1);
        check_eq("pres_ready",32'(ow_if.cmd_ready), 32'd1);
        check_eq("pres_busy", 32'(ow_if.busy), 32'd0);

        // Reset op, no slave
        slave_en = 1'b0;
        run_cmd(2'b00, 1'b0, 2'd0, 8'h00, lat, rd, pr);
        check_eq("nopres_bit", 32'(pr), 32'd0);
        check_eq("nopres_ch1", 32'(e_cnt[1]), 32'd0);
        check_eq("nopres_ch2", 32'(e_cnt[2]), 32'd0);

        // Byte write 0x55 normal speed, echo from pulled-up line
        run_cmd(2'b10, 1'b0, 2'd0, 8'h55, lat, rd, pr);
        check_eq("b55_lat",   32'(lat), 32'(560 * TICK_N + 2));
        check_eq("b55_data",  32'(rd), 32'h55);
        check_eq("b55_npulse",32'(npulse), 32'd8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("b55_pulse%0d", i), 32'(pulses[i]),
                     (i % 2 == 0) ? 32'(6 * TICK_N) : 32'(60 * TICK_N));

        // Overdrive read of 0xA3 with data 0xFF
        slave_en = 1'b1; slave_t = TICK_O; slave_bits = 8'hA3;
        run_cmd(2'b10, 1'b1, 2'd0, 8'hFF, lat, rd, pr);
        check_eq("ovd_lat",   32'(lat), 32'(560 * TICK_O + 2));
        check_eq("ovd_data",  32'(rd), 32'hA3);
        check_eq("ovd_pulse", 32'(pulses[0]), 32'(6 * TICK_O));
        slave_en = 1'b0; slave_t = TICK_N;

        // Channel 2 bit ops
        run_cmd(2'b01, 1'b0, 2'd2, 8'h00, lat, rd, pr);
        check_eq("c2w0_lat",  32'(lat), 32'(70 * TICK_N + 2));
        check_eq("c2w0_e2",   32'(e_cnt[2]), 32'(60 * TICK_N));
        check_eq("c2w0_e0",   32'(e_cnt[0] + e_cnt[1]), 32'd0);
        check_eq("c2w0_data", 32'(rd), 32'd0);
        run_cmd(2'b01, 1'b0, 2'd2, 8'h01, lat, rd, pr);
        check_eq("c2w1_e2",   32'(e_cnt[2]), 32'(6 * TICK_N));
        check_eq("c2w1_data", 32'(rd), 32'd1);

        // Out-of-range channel: no drive, response still returns
        run_cmd(2'b01, 1'b0, 2'd3, 8'h01, lat, rd, pr);
        check_eq("c3_lat",   32'(lat), 32'(70 * TICK_N + 2));
        check_eq("c3_e",     32'(e_cnt[0] + e_cnt[1] + e_cnt[2]), 32'd0);
        check_eq("c3_data",  32'(rd), 32'd0);
        slave_en = 1'b1;
        run_cmd(2'b00, 1'b0, 2'd3, 8'h00, lat, rd, pr);
        check_eq("c3_pres",  32'(pr), 32'd0);
        check_eq("c3_rst_e", 32'(e_cnt[0] + e_cnt[1] + e_cnt[2]), 32'd0);

        // NOP
        run_cmd(2'b11, 1'b0, 2'd0, 8'hFF, lat, rd, pr);
        check_eq("nop_lat",  32'(lat), 32'd2);
        check_eq("nop_data", 32'(rd), 32'd0);

        // Reset asserted in the middle of byte slot 4 (write 0 pulse active)
        clear_mon();
        @(negedge clk);
        ow_if.cmd_valid = 1'b1;
        ow_if.cmd_op    = 2'b10;
        ow_if.cmd_ovd   = 1'b0;
        ow_if.cmd_sel   = 2'd0;
        ow_if.cmd_data  = 8'h00;
        @(posedge clk);
        #1;
        ow_if.cmd_valid = 1'b0;
        repeat (3 * 70 * TICK_N + 100) @(posedge clk);
        @(negedge clk);
        check_eq("mid_e_before", 32'(owr_e), 32'd1);
        check_eq("mid_busy_before", 32'(ow_if.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_e",     32'(owr_e), 32'd0);
        check_eq("mid_busy",  32'(ow_if.busy), 32'd0);
        check_eq("mid_ready", 32'(ow_if.cmd_ready), 32'd1);
        check_eq("mid_rspv",  32'(ow_if.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check_eq("mid_no_rsp", 32'(rsp_seen), 32'd0);
        check_eq("mid_idle_e", 32'(owr_e), 32'd0);

        slave_en = 1'b1;
        run_cmd(2'b00, 1'b0, 2'd0, 8'h00, lat, rd, pr);
        check_eq("post_lat",  32'(lat), 32'(960 * TICK_N + 2));
        check_eq("post_pres", 32'(pr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
